// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and frame-length helper for the SPI master.
package spi_pkg;

  localparam logic [7:0] WR_OP = 8'h3C;
  localparam logic [7:0] RD_OP = 8'h5B;

  // Rising-edge numbers (counted from 1 at CSn fall) where each field begins.
  localparam logic [11:0] OP_FIRST_BIT      = 12'd2;
  localparam logic [11:0] DATA_FIRST_BIT    = OP_FIRST_BIT + 12'd8;
  localparam logic [11:0] RD_DATA_FIRST_BIT = DATA_FIRST_BIT + 12'd8;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  // Number of SCLK rises in a frame: start + opcode, plus a dummy byte for reads,
  // plus eight rises per data byte. An empty frame is start + opcode only.
  function automatic logic [11:0] frame_bits(input logic rd, input logic [11:0] nbytes);
    logic [11:0] data_bits;
    data_bits = nbytes << 3;
    if (nbytes == 12'd0) return DATA_FIRST_BIT - 12'd1;
    return rd ? (RD_DATA_FIRST_BIT - 12'd1 + data_bits) : (DATA_FIRST_BIT - 12'd1 + data_bits);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host handshake and SPI pad bundle between the register engine and spi_master.
interface spi_master_if #(parameter int LEN_W = 8);
  logic             start;
  logic             rw;
  logic [LEN_W-1:0] byte_num;
  logic [7:0]       tx_dat;
  logic             tx_req;
  logic [7:0]       rx_dat;
  logic             rx_vld;
  logic             busy;
  logic             done;
  logic             CSn;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;

  modport master (
    input  start, rw, byte_num, tx_dat, MISO,
    output tx_req, rx_dat, rx_vld, busy, done, CSn, SCLK, MOSI
  );

  modport slave (
    output start, rw, byte_num, tx_dat, MISO,
    input  tx_req, rx_dat, rx_vld, busy, done, CSn, SCLK, MOSI
  );
endinterface

// File: rtl/spi_clk_div.sv
// Phase timer: every CLK_DIV cycles raises phase_end; while toggle is set the
// registered SCLK flips at each phase end, with matching rise/fall strobes.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic dat_rcv_clk,
  input  logic sclk_rstn,
  input  logic en,
  input  logic toggle,
  output logic phase_end,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [7:0] cnt;

  assign phase_end = en && (cnt == 8'(CLK_DIV - 1));
  assign sclk_rise = phase_end && toggle && !sclk;
  assign sclk_fall = phase_end && toggle && sclk;

  // Phase counter and SCLK register; both park at zero while disabled.
  always_ff @(posedge dat_rcv_clk or negedge sclk_rstn) begin
    if (!sclk_rstn) begin
      cnt  <= 8'd0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= 8'd0;
      sclk <= 1'b0;
    end else begin
      cnt <= phase_end ? 8'd0 : cnt + 8'd1;
      if (phase_end && toggle) sclk <= !sclk;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: start bit, opcode, then write data or dummy byte + read data.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 8
) (
  input logic          dat_rcv_clk,
  input logic          sclk_rstn,
  spi_master_if.master bus
);
  import spi_pkg::*;

  // A new write byte is fetched on the rise just before each data byte; read
  // bytes complete on the last rise of each byte after the dummy byte.
  localparam logic [11:0] TX_LOAD_BIT = DATA_FIRST_BIT - 12'd1;
  localparam logic [11:0] RX_LAST_BIT = RD_DATA_FIRST_BIT + 12'd7;

  state_t           state, state_nxt;
  logic             accept;
  logic             phase_end, sclk, sclk_rise, sclk_fall;
  logic             rw_q, csn, mosi, tx_req, rx_vld, done;
  logic [11:0]      n_bits, bit_cnt, cnt_inc;
  logic [7:0]       tx_sr, rx_sr, rx_dat;
  logic [LEN_W-1:0] byte_num_w;
  logic             last_bit, tx_load, tx_fetch, rx_byte_end;

  assign byte_num_w  = bus.byte_num;
  assign cnt_inc     = bit_cnt + 12'd1;
  assign last_bit    = (bit_cnt == n_bits);
  assign tx_load     = (bit_cnt >= TX_LOAD_BIT) && (bit_cnt[2:0] == TX_LOAD_BIT[2:0]);
  assign tx_fetch    = (cnt_inc >= TX_LOAD_BIT) && (cnt_inc[2:0] == TX_LOAD_BIT[2:0]) && (cnt_inc != n_bits);
  assign rx_byte_end = (cnt_inc >= RX_LAST_BIT) && (cnt_inc[2:0] == RX_LAST_BIT[2:0]);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .dat_rcv_clk (dat_rcv_clk),
    .sclk_rstn   (sclk_rstn),
    .en          (state != IDLE),
    .toggle      (state inside {SETUP, SHIFT}),
    .phase_end   (phase_end),
    .sclk        (sclk),
    .sclk_rise   (sclk_rise),
    .sclk_fall   (sclk_fall)
  );

  // State register.
  always_ff @(posedge dat_rcv_clk or negedge sclk_rstn) begin
    if (!sclk_rstn) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; a start in the done cycle is deliberately not accepted.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (bus.start && !done) begin
               accept    = 1'b1;
               state_nxt = SETUP;
             end
      SETUP: if (phase_end) state_nxt = SHIFT;
      SHIFT: if (sclk_fall && last_bit) state_nxt = HOLD;
      HOLD:  if (phase_end) state_nxt = GAP;
      GAP:   if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: capture on accept, count/sample on rises, drive MOSI on falls.
  always_ff @(posedge dat_rcv_clk or negedge sclk_rstn) begin
    if (!sclk_rstn) begin
      rw_q    <= 1'b0;
      n_bits  <= 12'd0;
      bit_cnt <= 12'd0;
      tx_sr   <= 8'd0;
      rx_sr   <= 8'd0;
      rx_dat  <= 8'd0;
      csn     <= 1'b1;
      mosi    <= 1'b1;
      tx_req  <= 1'b0;
      rx_vld  <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every right-hand side sees the values
      // from before this edge regardless of statement order.
      csn    <= !(state_nxt inside {SETUP, SHIFT, HOLD});
      done   <= (state == GAP) && phase_end;
      tx_req <= 1'b0;
      rx_vld <= 1'b0;

      if (accept) begin
        rw_q    <= bus.rw;
        n_bits  <= frame_bits(bus.rw, 12'(byte_num_w));
        bit_cnt <= 12'd0;
        tx_sr   <= bus.rw ? RD_OP : WR_OP;
        mosi    <= 1'b0;
      end

      if (sclk_rise) begin
        bit_cnt <= cnt_inc;
        if (rw_q && cnt_inc >= RD_DATA_FIRST_BIT) rx_sr <= {rx_sr[6:0], bus.MISO};
        if (rw_q && rx_byte_end) begin
          rx_dat <= {rx_sr[6:0], bus.MISO};
          rx_vld <= 1'b1;
        end
        if (!rw_q && tx_fetch) tx_req <= 1'b1;
      end

      if (sclk_fall) begin
        if (last_bit) begin
          mosi <= 1'b1;
        end else if (tx_load) begin
          // Reads send an all-ones dummy byte and keep MOSI high afterwards.
          mosi  <= rw_q ? 1'b1 : bus.tx_dat[7];
          tx_sr <= rw_q ? 8'hFF : {bus.tx_dat[6:0], 1'b1};
        end else begin
          mosi  <= tx_sr[7];
          tx_sr <= {tx_sr[6:0], 1'b1};
        end
      end
    end
  end

  assign bus.CSn    = csn;
  assign bus.SCLK   = sclk;
  assign bus.MOSI   = mosi;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done;
  assign bus.tx_req = tx_req;
  assign bus.rx_vld = rx_vld;
  assign bus.rx_dat = rx_dat;

endmodule
